// File: rtl/game_pkg.sv
// Shared definitions for the memory game: tile codes, sequence sizing,
// difficulty lengths and the player input checker state encoding.
package game_pkg;

    // Tile codes as stored in the sequence memory
    localparam logic [1:0] TILE0 = 2'd0;
    localparam logic [1:0] TILE1 = 2'd1;
    localparam logic [1:0] TILE2 = 2'd2;
    localparam logic [1:0] TILE3 = 2'd3;

    // Sequence sizing shared with the playback controller
    localparam int GAME_ADDR_W  = 6;
    localparam int GAME_SEQ_MAX = 16;

    // Round lengths used by the top-level game FSM
    localparam int EASY_LEN   = 3;
    localparam int NORMAL_LEN = 6;
    localparam int HARD_LEN   = 9;

    // Player input checker states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_ARM,
        ST_WAIT_KEY,
        ST_COMPARE,
        ST_FLASH,
        ST_RELEASE,
        ST_PASS,
        ST_FAIL
    } pic_state_t;

    // Encode a pressed-key vector to a tile code; the lowest set bit wins,
    // which only matters for multi-key vectors that are rejected anyway.
    function automatic logic [1:0] onehot_to_tile(input logic [3:0] onehot);
        logic [1:0] tile;
        tile = TILE0;
        for (int i = 3; i >= 0; i--) begin
            if (onehot[i]) tile = 2'(i);
        end
        return tile;
    endfunction

endpackage

// File: rtl/key_sync_decode.sv
// Brings the asynchronous active-low tile keys into the clock domain and
// decodes them into press summary flags plus the tile code of a single press.
module key_sync_decode
    import game_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] keys,
    output logic       pressed_any,
    output logic       pressed_multi,
    output logic [1:0] pressed_tile,
    output logic       all_released
);

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_pressed;

    // Two-flop synchronizer on the raw key lines
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: synchronizer flops reset to 1 so that an active-low key reads
        // as released out of reset rather than as a spurious four-key press.
        if (!resetn) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= keys;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed     = ~r_sync2;
    assign pressed_any   = |w_pressed;
    // Clearing the lowest set bit leaves something only if two or more were set
    assign pressed_multi = (w_pressed & (w_pressed - 4'd1)) != 4'd0;
    assign all_released  = ~pressed_any;
    assign pressed_tile  = onehot_to_tile(w_pressed);

endmodule

// File: rtl/player_input_checker.sv
// Checks the player's tile presses against the stored sequence after
// playback, requests a confirmation flash for each correct press and reports
// round success or failure to the game FSM.
module player_input_checker
    import game_pkg::*;
#(
    parameter int SEQ_MAX        = GAME_SEQ_MAX,
    parameter int ADDR_W         = GAME_ADDR_W,
    parameter int TIMEOUT_CYCLES = 250_000_000,
    parameter int TMR_W          = 28
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [4:0]        difficulty,
    input  logic [3:0]        keys,
    output logic [ADDR_W-1:0] seq_rd_addr,
    input  logic [1:0]        seq_rd_data,
    output logic              flash_req,
    output logic [1:0]        flash_tile,
    input  logic              flash_done,
    output logic              busy,
    output logic [ADDR_W-1:0] progress,
    output logic              success,
    output logic              fail
);

    pic_state_t        r_state;
    pic_state_t        w_state_nxt;

    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W-1:0] r_len;
    logic [TMR_W-1:0]  r_timer;
    logic [1:0]        r_expected;
    logic [1:0]        r_tile;
    logic              r_busy;
    logic [ADDR_W-1:0] r_progress;
    logic              r_success;
    logic              r_fail;

    logic              w_pressed_any;
    logic              w_pressed_multi;
    logic [1:0]        w_pressed_tile;
    logic              w_all_released;

    logic [ADDR_W-1:0] w_len_clamped;
    logic              w_last;
    logic              w_timeout;
    logic              w_match;

    key_sync_decode u_key_sync_decode (
        .clock         (clock),
        .resetn        (resetn),
        .keys          (keys),
        .pressed_any   (w_pressed_any),
        .pressed_multi (w_pressed_multi),
        .pressed_tile  (w_pressed_tile),
        .all_released  (w_all_released)
    );

    // Difficulty values beyond the sequence memory depth are clamped
    assign w_len_clamped = (int'(difficulty) > SEQ_MAX) ? ADDR_W'(SEQ_MAX)
                                                        : ADDR_W'(difficulty);
    assign w_last        = (r_index + ADDR_W'(1)) == r_len;
    assign w_timeout     = r_timer == TMR_W'(TIMEOUT_CYCLES - 1);
    assign w_match       = r_tile == r_expected;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        // NOTE: the default keeps the current state, so no path through the
        // case leaves w_state_nxt unassigned and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = (w_len_clamped == '0) ? ST_PASS : ST_FETCH;
            end
            ST_FETCH:    w_state_nxt = ST_LATCH;
            ST_LATCH:    w_state_nxt = ST_ARM;
            ST_ARM: begin
                if (w_all_released) w_state_nxt = ST_WAIT_KEY;
            end
            ST_WAIT_KEY: begin
                // A press seen on the timeout cycle still gets compared
                if (w_pressed_multi)    w_state_nxt = ST_FAIL;
                else if (w_pressed_any) w_state_nxt = ST_COMPARE;
                else if (w_timeout)     w_state_nxt = ST_FAIL;
            end
            ST_COMPARE:  w_state_nxt = w_match ? ST_FLASH : ST_FAIL;
            ST_FLASH: begin
                if (flash_done) w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (w_all_released) w_state_nxt = w_last ? ST_PASS : ST_FETCH;
            end
            ST_PASS:     w_state_nxt = ST_IDLE;
            ST_FAIL:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Round datapath: index, length, timer, captured tiles and status flags
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_index    <= '0;
            r_len      <= '0;
            r_timer    <= '0;
            r_expected <= TILE0;
            r_tile     <= TILE0;
            r_busy     <= 1'b0;
            r_progress <= '0;
            r_success  <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len      <= w_len_clamped;
                        r_index    <= '0;
                        r_progress <= '0;
                        r_success  <= 1'b0;
                        r_fail     <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    r_expected <= seq_rd_data;
                    r_timer    <= '0;
                end
                ST_WAIT_KEY: begin
                    r_timer <= r_timer + TMR_W'(1);
                    if (w_pressed_any && !w_pressed_multi) r_tile <= w_pressed_tile;
                end
                ST_FLASH: begin
                    if (flash_done) r_progress <= r_index + ADDR_W'(1);
                end
                ST_RELEASE: begin
                    if (w_all_released && !w_last) r_index <= r_index + ADDR_W'(1);
                end
                default: ;
            endcase

            // Verdict flags land together with the PASS/FAIL state so the
            // game FSM sees them on the same cycle busy drops.
            if (w_state_nxt == ST_PASS) begin
                r_success <= 1'b1;
                r_busy    <= 1'b0;
            end
            if (w_state_nxt == ST_FAIL) begin
                r_fail <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign seq_rd_addr = r_index;
    assign flash_req   = (r_state == ST_COMPARE) && w_match;
    assign flash_tile  = r_tile;
    assign busy        = r_busy;
    assign progress    = r_progress;
    assign success     = r_success;
    assign fail        = r_fail;

endmodule
